mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Load/store sequencer directly upstream of the word-wide Data_Memory.
- Accepts byte, halfword and word load/store requests from the execute stage and drives the memory's MemRead/MemWrite/address/data pins.
- Implements sub-word stores as read-modify-write and sign/zero-extends sub-word loads.
- Returns one response per request through a valid/ready handshake.

Parameters:
- IDX_W, 16, width of the word index driven to memory (memory depth is 2^IDX_W words); upper address outputs are zero-filled to 32 bits.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request this cycle
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word; 11 is treated as word
- req_signed  in  1  sign-extend sub-word loads
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned access (with MAU_MISALIGN_TRAP_EN only)
- MemRead  out  1  to Data_Memory
- MemWrite  out  1  to Data_Memory
- read_address  out  32  word index {zeros, addr[IDX_W+1:2]}
- write_address  out  32  same encoding as read_address
- Write_data  out  32  full word to write
- MemData_out  in  32  combinational read data from Data_Memory

Behaviour:
- Reset: state IDLE; all registered outputs are 0. req_ready is 0 while reset is high and 1 in the first cycle after reset deasserts.
- req_ready = (state == IDLE). A request is accepted on a cycle where req_valid && req_ready. Accepted fields are latched into internal registers; request inputs are ignored at all other times.
- States:
  - IDLE: on accept, misaligned (trap build) -> RESP; load -> LOAD; word store -> ST_WR; byte/half store -> ST_RD.
  - LOAD: MemRead=1, read_address driven. MemData_out is latched at the clock edge and the lane is extracted. -> RESP.
  - ST_RD: MemRead=1. The old word is latched into the merge register. -> ST_WR.
  - ST_WR: MemWrite=1, Write_data = merged word (word store: req_wdata unchanged). -> RESP.
  - RESP: resp_valid=1 for exactly this cycle. -> IDLE.
- Outputs by state:
  - MemRead and MemWrite are never asserted together.
  - Both are 0 in IDLE and RESP; addresses and Write_data are 0 in IDLE.
- Latency from accept edge to resp_valid: load 2 cycles, word store 2, sub-word store 3, misaligned 1.
- Throughput: one request per 3–4 cycles. No back-pressure on the response; the consumer must take resp_valid when it is pulsed.
- Lanes are little-endian:
  - byte lane = addr[1:0], bits [8*lane+7 : 8*lane].
  - half lane = addr[1], bits [16*addr[1]+15 : 16*addr[1]].
  - Store merge replaces only the selected lane with the low bits of req_wdata.
- Load extension: sign-extend when req_signed=1, else zero-extend. Word loads pass through unchanged.
- Alignment: a halfword is misaligned when addr[0]=1; a word is misaligned when addr[1:0]!=0. Bytes are never misaligned.
- Address bits above IDX_W+1 are dropped, so addresses wrap modulo memory size.
- Reset mid-operation returns to IDLE at once with no write and no response. A store already in ST_WR when reset is sampled is not written.
- resp_rdata holds its value until the next RESP. It is 0 after reset, after stores and after errors.

Optional Feature:
- Macro: MAU_MISALIGN_TRAP_EN
- Defined:
  - Misaligned requests perform no memory access.
  - RESP with resp_err=1 and resp_rdata=0.
- Undefined:
  - resp_err is tied to 0.
  - Low address bits are forced aligned: halfword clears addr[0], word clears addr[1:0].
  - The access then proceeds normally.

Decomposition:
- Shared package mau_pkg holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - state encoding S_IDLE, S_LOAD, S_ST_RD, S_ST_WR, S_RESP.
- One combinational sub-module, mau_lane_align, performs load extraction/extension and store merge from (size, signed, addr[1:0], word, wdata). The FSM stays in the top level.

Test Plan:
- Word store 0xDEADBEEF @0x10, then word load @0x10 -> MemWrite pulse with write_address=4; load resp_rdata=0xDEADBEEF, resp_valid 2 cycles after accept.
- Word 0x11223344 at 0x20; byte store 0xAA @0x22 -> ST_RD then ST_WR with Write_data=0x11AA3344; resp_valid 3 cycles after accept.
- Memory 0x80F07F01 @0x30:
  - signed byte load @0x33 -> 0xFFFFFF80;
  - unsigned half load @0x32 -> 0x000080F0;
  - signed byte load @0x31 -> 0x0000007F.
- With MAU_MISALIGN_TRAP_EN: word load @0x41 -> no MemRead, resp_err=1, resp_rdata=0 after 1 cycle. Without the macro -> reads word index 0x10, resp_err=0.
- req_valid held high while busy -> only one accept per request; req_ready low in LOAD/ST_RD/ST_WR/RESP; back-to-back requests complete in order.
- Reset asserted during ST_RD of a byte store -> next cycle IDLE; no MemWrite, no resp_valid; memory word unchanged.

Source files
------------

// File: rtl/mau_pkg.sv
// Shared encodings and helpers for the load/store sequencer in front of Data_Memory.
package mau_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ST_RD,
    S_ST_WR,
    S_RESP
  } state_t;

  // Size 2'b11 behaves exactly like a word access.
  function automatic logic [1:0] norm_size(input logic [1:0] sz);
    return (sz == 2'b11) ? SZ_WORD : sz;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lo);
    logic r;
    case (sz)
      SZ_BYTE: r = 1'b0;
      SZ_HALF: r = lo[0];
      default: r = (lo != 2'b00);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mau_lane_align.sv
// Little-endian lane extract/extend for loads and lane merge for sub-word stores.
// Purely combinational; no latency, no flow control.
module mau_lane_align
  import mau_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merge
);

  logic [4:0]  w_bsh;
  logic [4:0]  w_hsh;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_bsh  = {i_lane, 3'b000};
  assign w_hsh  = {i_lane[1], 4'b0000};
  assign w_byte = i_word[w_bsh +: 8];
  assign w_half = i_word[w_hsh +: 16];

  always_comb begin
    o_load  = i_word;
    o_merge = i_wdata;
    case (i_size)
      SZ_BYTE: begin
        o_load  = {{24{i_signed & w_byte[7]}}, w_byte};
        o_merge = i_word;
        o_merge[w_bsh +: 8] = i_wdata[7:0];
      end
      SZ_HALF: begin
        o_load  = {{16{i_signed & w_half[15]}}, w_half};
        o_merge = i_word;
        o_merge[w_hsh +: 16] = i_wdata[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer for word-wide Data_Memory: load/word store 2 cycles, sub-word store 3 (RMW), trap 1.
// One request in flight (req_ready only in IDLE); response is a pulse with no back-pressure. Option: MAU_MISALIGN_TRAP_EN.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int IDX_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] read_address,
  output logic [31:0] write_address,
  output logic [31:0] Write_data,
  input  logic [31:0] MemData_out
);

  state_t             r_state;
  logic [1:0]         r_size;
  logic               r_signed;
  logic [1:0]         r_lane;
  logic [IDX_W-1:0]   r_idx;
  logic [31:0]        r_wdata;
  logic               r_mem_read;
  logic               r_mem_write;
  logic [31:0]        r_rd_addr;
  logic [31:0]        r_wr_addr;
  logic [31:0]        r_wr_data;
  logic [31:0]        r_rdata;
  logic               r_resp_vld;
`ifdef MAU_MISALIGN_TRAP_EN
  logic               r_resp_err;
`endif

  logic               w_req_ready;
  logic               w_accept;
  logic [1:0]         w_size;
  logic [1:0]         w_lane;
  logic [IDX_W-1:0]   w_idx;
  logic               w_misalign;
  logic [31:0]        w_load;
  logic [31:0]        w_merge;
  logic               w_unused;

  assign w_req_ready = (r_state == S_IDLE) && !reset;
  assign w_accept    = req_valid && w_req_ready;
  assign w_size      = norm_size(req_size);
  assign w_idx       = req_addr[IDX_W+1:2];
  assign w_unused    = ^req_addr[31:IDX_W+2];

  // Lane is always forced to the natural alignment of the size.
  assign w_lane = (w_size == SZ_BYTE) ? req_addr[1:0] :
                  (w_size == SZ_HALF) ? {req_addr[1], 1'b0} : 2'b00;

`ifdef MAU_MISALIGN_TRAP_EN
  assign w_misalign = is_misaligned(w_size, req_addr[1:0]);
`else
  assign w_misalign = 1'b0;
`endif

  mau_lane_align u_lane_align (
    .i_size   (r_size),
    .i_signed (r_signed),
    .i_lane   (r_lane),
    .i_word   (MemData_out),
    .i_wdata  (r_wdata),
    .o_load   (w_load),
    .o_merge  (w_merge)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_size      <= SZ_BYTE;
      r_signed    <= 1'b0;
      r_lane      <= 2'b00;
      r_idx       <= '0;
      r_wdata     <= 32'h0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_rd_addr   <= 32'h0;
      r_wr_addr   <= 32'h0;
      r_wr_data   <= 32'h0;
      r_rdata     <= 32'h0;
      r_resp_vld  <= 1'b0;
`ifdef MAU_MISALIGN_TRAP_EN
      r_resp_err  <= 1'b0;
`endif
    end else begin
      r_resp_vld <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_size   <= w_size;
            r_signed <= req_signed;
            r_lane   <= w_lane;
            r_idx    <= w_idx;
            r_wdata  <= req_wdata;
            if (w_misalign) begin
              r_state    <= S_RESP;
              r_resp_vld <= 1'b1;
              r_rdata    <= 32'h0;
`ifdef MAU_MISALIGN_TRAP_EN
              r_resp_err <= 1'b1;
`endif
            end else if (!req_write) begin
              r_state    <= S_LOAD;
              r_mem_read <= 1'b1;
              r_rd_addr  <= 32'(w_idx);
            end else if (w_size == SZ_WORD) begin
              r_state     <= S_ST_WR;
              r_mem_write <= 1'b1;
              r_wr_addr   <= 32'(w_idx);
              r_wr_data   <= req_wdata;
            end else begin
              r_state    <= S_ST_RD;
              r_mem_read <= 1'b1;
              r_rd_addr  <= 32'(w_idx);
            end
          end
        end
        S_LOAD: begin
          r_state    <= S_RESP;
          r_mem_read <= 1'b0;
          r_rd_addr  <= 32'h0;
          r_rdata    <= w_load;
          r_resp_vld <= 1'b1;
        end
        S_ST_RD: begin
          // Old word arrives this edge; the merged word goes straight to the write-data register.
          r_state     <= S_ST_WR;
          r_mem_read  <= 1'b0;
          r_rd_addr   <= 32'h0;
          r_mem_write <= 1'b1;
          r_wr_addr   <= 32'(r_idx);
          r_wr_data   <= w_merge;
        end
        S_ST_WR: begin
          r_state     <= S_RESP;
          r_mem_write <= 1'b0;
          r_wr_addr   <= 32'h0;
          r_wr_data   <= 32'h0;
          r_rdata     <= 32'h0;
          r_resp_vld  <= 1'b1;
        end
        S_RESP: begin
          r_state <= S_IDLE;
`ifdef MAU_MISALIGN_TRAP_EN
          r_resp_err <= 1'b0;
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready     = w_req_ready;
  assign resp_valid    = r_resp_vld;
  assign resp_rdata    = r_rdata;
  assign MemRead       = r_mem_read;
  // A store caught in ST_WR by reset must not reach the array on the reset edge.
  assign MemWrite      = r_mem_write && !reset;
  assign read_address  = r_rd_addr;
  assign write_address = r_wr_addr;
  assign Write_data    = r_wr_data;
`ifdef MAU_MISALIGN_TRAP_EN
  assign resp_err      = r_resp_err;
`else
  assign resp_err      = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural Data_Memory and a response scoreboard.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] read_address;
  logic [31:0] write_address;
  logic [31:0] Write_data;
  logic [31:0] MemData_out;

  mem_access_unit #(.IDX_W(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_size      (req_size),
    .req_signed    (req_signed),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .resp_err      (resp_err),
    .MemRead       (MemRead),
    .MemWrite      (MemWrite),
    .read_address  (read_address),
    .write_address (write_address),
    .Write_data    (Write_data),
    .MemData_out   (MemData_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [31:0] cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem [0:65535];
  int          n_assert = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  int          both_cnt = 0;
  int          acc_cnt = 0;
  int          n_issued = 0;

  assign MemData_out = mem[read_address[15:0]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (MemWrite) begin
      mem[write_address[15:0]] = Write_data;
      wr_cnt <= wr_cnt + 1;
    end
    if (MemRead) rd_cnt <= rd_cnt + 1;
    if (MemRead && MemWrite) both_cnt <= both_cnt + 1;
    if (req_valid && req_ready) acc_cnt <= acc_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  // Scoreboard: every response pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (resp_valid) begin
      exp_t e;
      n_assert++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_resp: observed resp_valid=1 expected no response");
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("resp_rdata", resp_rdata, e.rdata);
        chk1("resp_err", resp_err, e.err);
        chk("resp_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic drive(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd);
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    req_valid  = 1'b1;
  endtask

  task automatic wait_ready();
    int b = 0;
    while (!req_ready && b < 50) begin
      @(negedge clk);
      b++;
    end
    n_assert++;
    assert (req_ready === 1'b1) else begin
      n_fail++;
      $error("FAIL ready_timeout: observed req_ready=%b expected 1", req_ready);
    end
  endtask

  // Drives one request, pushes its expected response, returns #1 after the accept edge.
  task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] er, input logic ee, input int lat);
    exp_t e;
    @(negedge clk);
    drive(w, sz, sg, a, wd);
    wait_ready();
    e.rdata = er;
    e.err   = ee;
    e.cyc   = 32'(cyc + lat);
    exp_q.push_back(e);
    n_issued++;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int b = 0;
    while (exp_q.size() != 0 && b < 100) begin
      @(negedge clk);
      b++;
    end
    chk("drain_outstanding", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd0;
    int wr0;
    int acc0;
    logic mis;
    for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
    reset = 1'b1;
    drive(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    req_valid = 1'b0;
`ifdef MAU_MISALIGN_TRAP_EN
    mis = 1'b1;
`else
    mis = 1'b0;
`endif

    repeat (3) @(negedge clk);
    chk1("rst_req_ready", req_ready, 1'b0);
    chk1("rst_memread", MemRead, 1'b0);
    chk1("rst_memwrite", MemWrite, 1'b0);
    chk1("rst_resp_valid", resp_valid, 1'b0);
    chk1("rst_resp_err", resp_err, 1'b0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_read_address", read_address, 32'h0);
    chk("rst_write_address", write_address, 32'h0);
    chk("rst_write_data", Write_data, 32'h0);
    reset = 1'b0;
    #1 chk1("ready_after_reset", req_ready, 1'b1);

    // Word store then word load
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2);
    @(negedge clk);
    chk1("wst_memwrite", MemWrite, 1'b1);
    chk1("wst_memread", MemRead, 1'b0);
    chk("wst_write_address", write_address, 32'd4);
    chk("wst_write_data", Write_data, 32'hDEADBEEF);
    drain();
    chk("wst_mem", mem[4], 32'hDEADBEEF);
    chk("idle_read_address", read_address, 32'h0);
    chk("idle_write_data", Write_data, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2);
    @(negedge clk);
    chk1("wld_memread", MemRead, 1'b1);
    chk("wld_read_address", read_address, 32'd4);
    drain();

    // Byte store read-modify-write
    mem[8] = 32'h11223344;
    issue(1'b1, 2'b00, 1'b0, 32'h22, 32'h000000AA, 32'h0, 1'b0, 3);
    @(negedge clk);
    chk1("bst_rd_memread", MemRead, 1'b1);
    chk1("bst_rd_memwrite", MemWrite, 1'b0);
    chk1("bst_rd_ready", req_ready, 1'b0);
    chk("bst_rd_read_address", read_address, 32'd8);
    @(negedge clk);
    chk1("bst_wr_memwrite", MemWrite, 1'b1);
    chk1("bst_wr_memread", MemRead, 1'b0);
    chk1("bst_wr_ready", req_ready, 1'b0);
    chk("bst_wr_write_address", write_address, 32'd8);
    chk("bst_wr_write_data", Write_data, 32'h11AA3344);
    drain();
    chk("bst_mem", mem[8], 32'h11AA3344);

    // Sub-word load extraction and extension
    mem[12] = 32'h80F07F01;
    issue(1'b0, 2'b00, 1'b1, 32'h33, 32'h0, 32'hFFFFFF80, 1'b0, 2);
    issue(1'b0, 2'b01, 1'b0, 32'h32, 32'h0, 32'h000080F0, 1'b0, 2);
    issue(1'b0, 2'b00, 1'b1, 32'h31, 32'h0, 32'h0000007F, 1'b0, 2);
    issue(1'b0, 2'b01, 1'b1, 32'h32, 32'h0, 32'hFFFF80F0, 1'b0, 2);
    issue(1'b0, 2'b01, 1'b1, 32'h30, 32'h0, 32'h00007F01, 1'b0, 2);
    issue(1'b0, 2'b00, 1'b0, 32'h33, 32'h0, 32'h00000080, 1'b0, 2);
    issue(1'b0, 2'b11, 1'b1, 32'h30, 32'h0, 32'h80F07F01, 1'b0, 2);
    // Address bits above the index wrap modulo memory size
    issue(1'b0, 2'b10, 1'b0, 32'h00040010, 32'h0, 32'hDEADBEEF, 1'b0, 2);
    drain();

    // Misaligned accesses
    mem[16] = 32'hCAFEF00D;
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    if (mis) begin
      issue(1'b0, 2'b10, 1'b0, 32'h41, 32'h0, 32'h0, 1'b1, 1);
      issue(1'b1, 2'b01, 1'b0, 32'h43, 32'h00005566, 32'h0, 1'b1, 1);
      drain();
      chk("mis_no_read", 32'(rd_cnt - rd0), 32'd0);
      chk("mis_no_write", 32'(wr_cnt - wr0), 32'd0);
      issue(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'hCAFEF00D, 1'b0, 2);
    end else begin
      issue(1'b0, 2'b10, 1'b0, 32'h41, 32'h0, 32'hCAFEF00D, 1'b0, 2);
      @(negedge clk);
      chk("mis_read_address", read_address, 32'h10);
      issue(1'b1, 2'b01, 1'b0, 32'h43, 32'h00005566, 32'h0, 1'b0, 3);
      issue(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h5566F00D, 1'b0, 2);
    end
    drain();

    // req_valid held high through a busy request: exactly one accept
    @(negedge clk);
    drive(1'b0, 2'b00, 1'b0, 32'h30, 32'h0);
    wait_ready();
    acc0 = acc_cnt;
    exp_q.push_back('{rdata: 32'h01, err: 1'b0, cyc: 32'(cyc + 2)});
    n_issued++;
    @(negedge clk);
    chk1("held_ready_load", req_ready, 1'b0);
    @(negedge clk);
    chk1("held_ready_resp", req_ready, 1'b0);
    req_valid = 1'b0;
    @(negedge clk);
    chk("held_one_accept", 32'(acc_cnt - acc0), 32'd1);
    drain();

    // Back-to-back requests complete in order
    issue(1'b1, 2'b10, 1'b0, 32'h60, 32'h0BADF00D, 32'h0, 1'b0, 2);
    issue(1'b0, 2'b00, 1'b0, 32'h60, 32'h0, 32'h0000000D, 1'b0, 2);
    issue(1'b1, 2'b01, 1'b0, 32'h62, 32'hFFFF1234, 32'h0, 1'b0, 3);
    issue(1'b0, 2'b10, 1'b0, 32'h60, 32'h0, 32'h1234F00D, 1'b0, 2);
    drain();

    // Reset during ST_RD of a byte store
    mem[20] = 32'h01020304;
    wr0 = wr_cnt;
    @(negedge clk);
    drive(1'b1, 2'b00, 1'b0, 32'h51, 32'h000000EE);
    wait_ready();
    n_issued++;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk1("rmw_st_rd_memread", MemRead, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    chk1("rst_mid_memwrite", MemWrite, 1'b0);
    chk1("rst_mid_memread", MemRead, 1'b0);
    chk1("rst_mid_resp_valid", resp_valid, 1'b0);
    chk("rst_mid_resp_rdata", resp_rdata, 32'h0);
    reset = 1'b0;
    #1 chk1("rst_mid_ready", req_ready, 1'b1);
    repeat (4) @(negedge clk);
    chk("rst_mid_mem", mem[20], 32'h01020304);
    chk("rst_mid_no_write", 32'(wr_cnt - wr0), 32'd0);

    // Reset while a word store sits in ST_WR
    mem[21] = 32'h0A0B0C0D;
    @(negedge clk);
    drive(1'b1, 2'b10, 1'b0, 32'h54, 32'h99999999);
    wait_ready();
    n_issued++;
    @(posedge clk);
    #1 req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk1("rst_stwr_memwrite", MemWrite, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_stwr_mem", mem[21], 32'h0A0B0C0D);
    chk("rst_stwr_no_write", 32'(wr_cnt - wr0), 32'd0);

    chk("rd_wr_exclusive", 32'(both_cnt), 32'd0);
    chk("accept_count", 32'(acc_cnt), 32'(n_issued));
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
